// File: rtl/serial_adder_pkg.sv
// Purpose: shared types and helpers for the multi-cycle serial adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter width: clog2 of the chunk count, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// Purpose: combinational ripple chain of W full-adder cells.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports: a, b (W bits), cin -> s (W bits), cout; with SERIAL_ADDER_OVF_EN also
// c_msb, the carry into the top cell (used for signed overflow).
module fa_slice #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
`ifdef SERIAL_ADDER_OVF_EN
    output logic         c_msb,
`endif
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[W];
`ifdef SERIAL_ADDER_OVF_EN
    assign c_msb = c[W-1];
`endif

endmodule

// File: rtl/serial_adder.sv
// Purpose: WIDTH-bit adder with carry-in, BITS_PER_CYCLE bits per clock.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+N.
// Backpressure: start ignored while busy; accepted in IDLE or in the DONE cycle.
//
// Ports: clk, rst_n (sync, active-low), start, a, b, c_in in;
// busy, done (1-cycle pulse), sum, c_out out. Optional macro
// SERIAL_ADDER_OVF_EN adds registered output ovf (signed overflow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             c_out
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = cnt_width(N);

    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
        $error("serial_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 1");
    end

    state_t                    state;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          res_sh;
    logic                      carry;
    logic [CW-1:0]             cnt;

    logic [BITS_PER_CYCLE-1:0] s_chunk;
    logic                      c_chunk;
    logic [WIDTH-1:0]          res_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic                      c_msb;
`endif

    fa_slice #(.W(BITS_PER_CYCLE)) u_fa_slice (
        .a    (a_sh[BITS_PER_CYCLE-1:0]),
        .b    (b_sh[BITS_PER_CYCLE-1:0]),
        .cin  (carry),
        .s    (s_chunk),
`ifdef SERIAL_ADDER_OVF_EN
        .c_msb(c_msb),
`endif
        .cout (c_chunk)
    );

    // New chunk enters at the MSB end; after N chunks the LSB chunk has
    // travelled down to bit 0. Written with shifts so N == 1 stays legal.
    assign res_next = (res_sh >> BITS_PER_CYCLE)
                    | (WIDTH'(s_chunk) << (WIDTH - BITS_PER_CYCLE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= c_in;
                        res_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> BITS_PER_CYCLE;
                    b_sh   <= b_sh >> BITS_PER_CYCLE;
                    carry  <= c_chunk;
                    res_sh <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        sum   <= res_next;
                        c_out <= c_chunk;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= c_msb ^ c_chunk;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
